// File: rtl/nanorv32_rf_ctx_seq.sv
// Context save/restore sequencer: streams regfile registers REG_FIRST..REG_LAST
// to a memory frame on interrupt entry, and back through the second write port on exit.
module nanorv32_rf_ctx_seq #(
    parameter int unsigned REG_FIRST = 1,
    parameter int unsigned REG_LAST  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        save_req,
    input  logic        restore_req,
    input  logic [31:0] frame_base,
    output logic        busy,
    output logic        done,
    output logic        core_stall,
    output logic [4:0]  rf_sel_porta,
    input  logic [31:0] rf_porta,
    output logic [4:0]  rf_sel_rd2,
    output logic [31:0] rf_rd2,
    output logic        rf_write_rd2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SAVE  = 3'd1;
    localparam logic [2:0] ST_RLOAD = 3'd2;
    localparam logic [2:0] ST_RWB   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [4:0] IDX_FIRST = 5'(REG_FIRST);
    localparam logic [4:0] IDX_LAST  = 5'(REG_LAST);

    logic [2:0]  state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] base_q, base_d;
    logic [31:0] buf_q, buf_d;

    logic [4:0]  idxOffset;
    logic [31:0] frameAddr;
    logic        lastIdx;

    // Frame slot address; the sum is allowed to wrap past 2^32.
    assign idxOffset = idx_q - IDX_FIRST;
    assign frameAddr = base_q + {25'd0, idxOffset, 2'b00};
    assign lastIdx   = (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                // Save wins a tie; the losing request is simply dropped.
                if (save_req) begin
                    base_d  = frame_base & 32'hFFFF_FFFC;
                    idx_d   = IDX_FIRST;
                    state_d = ST_SAVE;
                end else if (restore_req) begin
                    base_d  = frame_base & 32'hFFFF_FFFC;
                    idx_d   = IDX_FIRST;
                    state_d = ST_RLOAD;
                end
            end
            ST_SAVE: begin
                if (mem_ready) begin
                    if (lastIdx) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            ST_RLOAD: begin
                if (mem_ready) begin
                    buf_d   = mem_rdata;
                    state_d = ST_RWB;
                end
            end
            ST_RWB: begin
                if (lastIdx) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = ST_RLOAD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 5'd0;
            base_q  <= 32'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
        end
    end

    // All outputs decode from registered state only, so reset forces them to 0.
    always_comb begin
        rf_sel_porta = 5'd0;
        rf_sel_rd2   = 5'd0;
        rf_rd2       = 32'd0;
        rf_write_rd2 = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        done         = 1'b0;
        case (state_q)
            ST_SAVE: begin
                rf_sel_porta = idx_q;
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr     = frameAddr;
                mem_wdata    = rf_porta;
            end
            ST_RLOAD: begin
                mem_req  = 1'b1;
                mem_addr = frameAddr;
            end
            ST_RWB: begin
                rf_sel_rd2   = idx_q;
                rf_rd2       = buf_q;
                rf_write_rd2 = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign core_stall = busy;

endmodule
